// File: rtl/tex_fill_pkg.sv
// Shared types and geometry helpers for the texture-cache line-fill path.
package tex_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } fill_state_e;

  function automatic int beats_f(input int line_bytes, input int beat_bytes);
    return line_bytes / beat_bytes;
  endfunction

  function automatic int offset_bits_f(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/tex_line_fill_engine_chk.sv
// Simulation-only protocol checker: a memory beat may only arrive while a fill is in progress.
module tex_line_fill_engine_chk
  import tex_fill_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  input fill_state_e state_i,
  input logic        mem_rsp_valid_i
);

  // Flag stray read data returned outside FILL.
  always @(posedge clk) begin
    if (rst_n && mem_rsp_valid_i) begin
      assert (state_i == FILL)
        else $error("tex_line_fill_engine: mem_rsp_valid outside FILL, beat dropped");
    end
  end

endmodule

// File: rtl/tex_line_fill_engine.sv
// Line-fill responder: reads one cache line as sequential memory beats and returns it in one pulse.
module tex_line_fill_engine
  import tex_fill_pkg::*;
#(
  parameter int LINE_BYTES      = 64,
  parameter int BEAT_BYTES      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss_req_valid,
  input  logic [31:0]             miss_req_addr,
  output logic                    miss_req_ready,
  output logic                    miss_resp_valid,
  output logic [LINE_BYTES*8-1:0] miss_resp_data,
  output logic                    mem_req_valid,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [BEAT_BYTES*8-1:0] mem_rsp_data,
  output logic                    busy
);

  localparam int BEATS       = beats_f(LINE_BYTES, BEAT_BYTES);
  localparam int OFFSET_BITS = offset_bits_f(LINE_BYTES);
  localparam int CW          = $clog2(BEATS) + 1;
  localparam int WW          = BEAT_BYTES * 8;
  localparam int LW          = LINE_BYTES * 8;

  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]   BASE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  fill_state_e   state_q;
  logic [31:0]   base_q;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [LW-1:0] line_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          mem_req_valid_q, mem_req_valid_d;
  logic [31:0]   mem_req_addr_q, mem_req_addr_d;
  logic          busy_q;

  logic          issue_fire_s;
  logic          rsp_fire_s;
  logic          last_rsp_s;
  logic [31:0]   accept_base_s;

  // Post-handshake counters and the request that follows from them, so the beat request leaves a flop.
  always_comb begin
    issue_fire_s    = mem_req_valid_q & mem_req_ready;
    rsp_fire_s      = (state_q == FILL) & mem_rsp_valid;
    issue_cnt_d     = issue_cnt_q + {{(CW-1){1'b0}}, issue_fire_s};
    rsp_cnt_d       = rsp_cnt_q + {{(CW-1){1'b0}}, rsp_fire_s};
    mem_req_valid_d = (issue_cnt_d < BEATS_C) && ((issue_cnt_d - rsp_cnt_d) < MAXO_C);
    mem_req_addr_d  = base_q + (32'(issue_cnt_d) * 32'(BEAT_BYTES));
    last_rsp_s      = rsp_fire_s && (rsp_cnt_q == LAST_C);
    accept_base_s   = miss_req_addr & BASE_MASK;
  end

  // Fill FSM with counters, line shift register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= 32'd0;
      issue_cnt_q     <= '0;
      rsp_cnt_q       <= '0;
      line_q          <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= 32'd0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          if (miss_req_valid && req_ready_q) begin
            state_q         <= FILL;
            base_q          <= accept_base_s;
            issue_cnt_q     <= '0;
            rsp_cnt_q       <= '0;
            line_q          <= '0;
            req_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= accept_base_s;
          end else begin
            req_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
          end
        end
        FILL: begin
          issue_cnt_q <= issue_cnt_d;
          rsp_cnt_q   <= rsp_cnt_d;
          // Beats arrive in order, so shifting in at the top leaves word 0 in the lowest slot.
          if (rsp_fire_s) begin
            line_q <= {mem_rsp_data, line_q[LW-1:WW]};
          end
          if (last_rsp_s) begin
            state_q         <= RESP;
            resp_valid_q    <= 1'b1;
            mem_req_valid_q <= 1'b0;
          end else begin
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q         <= IDLE;
          resp_valid_q    <= 1'b0;
          req_ready_q     <= 1'b0;
          mem_req_valid_q <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  assign miss_req_ready  = req_ready_q;
  assign miss_resp_valid = resp_valid_q;
  assign miss_resp_data  = line_q;
  assign mem_req_valid   = mem_req_valid_q;
  assign mem_req_addr    = mem_req_addr_q;
  assign busy            = busy_q;

`ifndef SYNTHESIS
  tex_line_fill_engine_chk u_chk (
    .clk             (clk),
    .rst_n           (rst_n),
    .state_i         (state_q),
    .mem_rsp_valid_i (mem_rsp_valid)
  );
`endif

endmodule

// File: tb/tb_tex_line_fill_engine.sv
// Randomized scoreboard bench: a memory model answers beats, a monitor compares each line pulse.
module tb_tex_line_fill_engine;

  localparam int LB = 64;
  localparam int BB = 4;
  localparam int MO = 2;
  localparam int NB = LB / BB;
  localparam int LAT_IDEAL = NB + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miss_req_valid = 1'b0;
  logic [31:0]   miss_req_addr = 32'd0;
  logic          miss_req_ready;
  logic          miss_resp_valid;
  logic [511:0]  miss_resp_data;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic [31:0]   mem_rsp_data = 32'd0;
  logic          busy;

  always #5 clk = ~clk;

  tex_line_fill_engine #(.LINE_BYTES(LB), .BEAT_BYTES(BB), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req_valid(miss_req_valid), .miss_req_addr(miss_req_addr), .miss_req_ready(miss_req_ready),
    .miss_resp_valid(miss_resp_valid), .miss_resp_data(miss_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy)
  );

  int pass_n = 0;
  int chk_n  = 0;

  task automatic check(input bit ok, input string name, input logic [511:0] act, input logic [511:0] exp);
    chk_n++;
    if (ok) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // memory contents model
  logic [31:0] mem_base = 32'hA000_0000;
  bit          mem_mix  = 1'b0;
  bit          rdy_rand = 1'b0;
  int          lat      = 1;
  bit          check_lat = 1'b1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem_mix) return mem_base ^ (a * 32'h9E37_79B1);
    else         return mem_base + {28'd0, a[5:2]};
  endfunction

  function automatic logic [511:0] ref_line(input logic [31:0] addr);
    logic [511:0] l;
    logic [31:0]  base;
    base = addr & 32'hFFFF_FFC0;
    l = '0;
    for (int k = 0; k < NB; k++) l[k*32 +: 32] = word_at(base + 32'(k * BB));
    return l;
  endfunction

  logic [31:0]  exp_addr_q[$];
  logic [511:0] exp_line_q[$];
  int           exp_acc_q[$];
  int           pend_due_q[$];
  logic [31:0]  pend_addr_q[$];

  int cyc = 0;
  int accepts_n = 0;
  int pulses_n = 0;
  int rsp_in_fill = 0;
  int last_acc_cyc = 0;
  int last_pulse_cyc = 0;
  bit prev_resp = 1'b0;

  logic [31:0]  m_addr;
  logic [511:0] m_line;
  int           m_acc;
  logic [31:0]  m_base;

  // Memory model, accept detection and response monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_addr_q.delete(); exp_line_q.delete(); exp_acc_q.delete();
      pend_due_q.delete(); pend_addr_q.delete();
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      prev_resp = 1'b0;
      rsp_in_fill = 0;
    end else begin
      if (miss_resp_valid === 1'b1) begin
        pulses_n++;
        last_pulse_cyc = cyc;
        check(!prev_resp, "resp_pulse_width", 512'(prev_resp), 512'd0);
        if (exp_line_q.size() == 0) begin
          check(1'b0, "unexpected_resp", miss_resp_data, 512'd0);
        end else begin
          m_line = exp_line_q.pop_front();
          m_acc  = exp_acc_q.pop_front();
          check(miss_resp_data === m_line, "line_data", miss_resp_data, m_line);
          if (check_lat) check(cyc - m_acc == LAT_IDEAL, "latency", 512'(cyc - m_acc), 512'(LAT_IDEAL));
        end
      end else if (miss_resp_valid !== 1'b0) begin
        check(1'b0, "resp_valid_known", 512'(miss_resp_valid), 512'd0);
      end
      prev_resp = (miss_resp_valid === 1'b1);

      if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
        void'(pend_due_q.pop_front());
        m_addr = pend_addr_q.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word_at(m_addr);
        rsp_in_fill++;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
      end

      mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_req_valid && mem_req_ready) begin
        if (exp_addr_q.size() == 0) begin
          check(1'b0, "unexpected_mem_req", 512'(mem_req_addr), 512'd0);
        end else begin
          m_addr = exp_addr_q.pop_front();
          check(mem_req_addr == m_addr, "mem_req_addr", 512'(mem_req_addr), 512'(m_addr));
        end
        pend_due_q.push_back(cyc + lat);
        pend_addr_q.push_back(mem_req_addr);
        check(pend_due_q.size() <= MO, "outstanding", 512'(pend_due_q.size()), 512'(MO));
      end

      if (miss_req_valid && miss_req_ready) begin
        accepts_n++;
        last_acc_cyc = cyc;
        rsp_in_fill = 0;
        exp_line_q.push_back(ref_line(miss_req_addr));
        exp_acc_q.push_back(cyc);
        m_base = miss_req_addr & 32'hFFFF_FFC0;
        for (int k = 0; k < NB; k++) exp_addr_q.push_back(m_base + 32'(k * BB));
      end
    end
  end

  task automatic start_fill(input logic [31:0] a, input bit hold);
    int n0;
    @(posedge clk); #1;
    miss_req_valid = 1'b1;
    miss_req_addr  = a;
    n0 = accepts_n;
    for (int i = 0; i < 50 && accepts_n == n0; i++) begin
      @(posedge clk); #1;
    end
    check(accepts_n == n0 + 1, "accept", 512'(accepts_n - n0), 512'd1);
    if (!hold) miss_req_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int target);
    for (int i = 0; i < 2000 && pulses_n < target; i++) begin
      @(posedge clk); #1;
    end
    check(pulses_n >= target, "resp_timeout", 512'(pulses_n), 512'(target));
  endtask

  int exp_pulses = 0;
  int n_before;
  int p_before;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check(miss_req_ready == 1'b0, "rst_ready", 512'(miss_req_ready), 512'd0);
    check(busy == 1'b0, "rst_busy", 512'(busy), 512'd0);
    check(mem_req_valid == 1'b0, "rst_mem_req_valid", 512'(mem_req_valid), 512'd0);
    check(miss_resp_valid === 1'b0, "rst_resp_valid", 512'(miss_resp_valid), 512'd0);
    check(miss_resp_data === 512'd0, "rst_resp_data", miss_resp_data, 512'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(miss_req_ready == 1'b1, "idle_ready", 512'(miss_req_ready), 512'd1);

    // directed ideal fill at 0x1234
    start_fill(32'h0000_1234, 1'b0);
    check(busy == 1'b1, "busy_in_fill", 512'(busy), 512'd1);
    check(miss_req_ready == 1'b0, "ready_in_fill", 512'(miss_req_ready), 512'd0);
    exp_pulses++;
    wait_pulses(exp_pulses);
    check(miss_resp_data[31:0] == 32'hA000_0000, "word0", 512'(miss_resp_data[31:0]), 512'hA000_0000);
    check(miss_resp_data[511:480] == 32'hA000_000F, "word15", 512'(miss_resp_data[511:480]), 512'hA000_000F);
    check(busy == 1'b0, "busy_after", 512'(busy), 512'd0);

    // random addresses and contents, ideal memory: issue and response coincide every beat
    mem_mix = 1'b1;
    for (int t = 0; t < 4; t++) begin
      mem_base = $urandom;
      start_fill($urandom, 1'b0);
      exp_pulses++;
      wait_pulses(exp_pulses);
    end

    // random backpressure, long latency
    rdy_rand = 1'b1; lat = 5; check_lat = 1'b0;
    for (int t = 0; t < 4; t++) begin
      mem_base = $urandom;
      start_fill($urandom, 1'b0);
      exp_pulses++;
      wait_pulses(exp_pulses);
    end

    // request held high through FILL and RESP, new address right after the pulse
    rdy_rand = 1'b0; lat = 1; check_lat = 1'b1;
    mem_base = $urandom;
    start_fill(32'h0000_4440, 1'b1);
    n_before = accepts_n;
    for (int i = 0; i < 100 && miss_resp_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check(miss_resp_valid === 1'b1, "held_resp_seen", 512'(miss_resp_valid), 512'd1);
    check(accepts_n == n_before, "no_duplicate_fill", 512'(accepts_n), 512'(n_before));
    miss_req_addr = 32'h0000_8000;
    exp_pulses++;
    n_before = accepts_n;
    for (int i = 0; i < 10 && accepts_n == n_before; i++) begin
      @(posedge clk); #1;
    end
    miss_req_valid = 1'b0;
    check(accepts_n == n_before + 1, "second_accept", 512'(accepts_n - n_before), 512'd1);
    check(last_acc_cyc == last_pulse_cyc + 1, "back_to_back", 512'(last_acc_cyc - last_pulse_cyc), 512'd1);
    exp_pulses++;
    wait_pulses(exp_pulses);

    // reset after 7 beats returned
    lat = 2; check_lat = 1'b0;
    mem_base = $urandom;
    start_fill($urandom, 1'b0);
    for (int i = 0; i < 200 && rsp_in_fill < 7; i++) begin
      @(posedge clk); #1;
    end
    check(rsp_in_fill == 7, "beats_before_reset", 512'(rsp_in_fill), 512'd7);
    p_before = pulses_n;
    rst_n = 1'b0;
    #1;
    check(busy == 1'b0, "abort_busy", 512'(busy), 512'd0);
    check(miss_resp_valid === 1'b0, "abort_resp_valid", 512'(miss_resp_valid), 512'd0);
    check(mem_req_valid == 1'b0, "abort_mem_req", 512'(mem_req_valid), 512'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(pulses_n == p_before, "abort_no_pulse", 512'(pulses_n), 512'(p_before));
    mem_base = $urandom;
    start_fill($urandom, 1'b0);
    exp_pulses++;
    wait_pulses(exp_pulses);

    repeat (30) @(posedge clk);
    #1;
    check(pulses_n == exp_pulses, "total_pulses", 512'(pulses_n), 512'(exp_pulses));
    check(exp_line_q.size() == 0, "scoreboard_empty", 512'(exp_line_q.size()), 512'd0);
    check(exp_addr_q.size() == 0, "addr_queue_empty", 512'(exp_addr_q.size()), 512'd0);
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_n, chk_n);
    $fatal(1);
  end

endmodule
